// File: rtl/net_tx_scheduler.sv
// Transmit scheduler for the 5-wire link: data packet load/start/retransmit sequencing,
// sequence-number tracking, and arbitration of the shared handshake sender.
module net_tx_scheduler #(
  parameter int   TIMEOUT_CYCLES = 150,
  parameter int   MAX_RETRIES    = 4,
  parameter logic INIT_SEQ       = 1'b0,
  localparam int  RW             = $clog2(MAX_RETRIES + 1),
  localparam int  TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          game_active,
  input  logic          update_data,
  input  logic          ack_received,
  input  logic          received_seqNum_h,
  input  logic          send_ready_ACK,
  input  logic          send_game_lost,
  input  logic          send_done,
  input  logic          send_done_h,
  output logic          load_data,
  output logic          send_start,
  output logic          load_hnd,
  output logic          hnd_is_lost,
  output logic          send_start_h,
  output logic          seq_num,
  output logic [RW-1:0] retry_cnt,
  output logic          link_down
);

  typedef enum logic [1:0] {D_IDLE, D_LOAD, D_SEND, D_WAIT_ACK} d_state_t;
  typedef enum logic [1:0] {H_IDLE, H_LOAD, H_SEND} h_state_t;

  d_state_t d_state, d_state_nxt;
  h_state_t h_state, h_state_nxt;
  logic data_pend, data_pend_nxt, ack_pend, ack_pend_nxt, lost_pend, lost_pend_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0] d_blank, d_blank_nxt, h_blank, h_blank_nxt;
  logic seq_q, seq_nxt, link_q, link_nxt, lost_q, lost_nxt;
  logic [RW-1:0] retry_q, retry_nxt;
  logic ack_valid, timeout;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      d_state   <= D_IDLE;
      h_state   <= H_IDLE;
      data_pend <= 1'b0;
      ack_pend  <= 1'b0;
      lost_pend <= 1'b0;
      timer     <= '0;
      d_blank   <= '0;
      h_blank   <= '0;
      seq_q     <= INIT_SEQ;
      link_q    <= 1'b0;
      lost_q    <= 1'b0;
      retry_q   <= '0;
    end else begin
      d_state   <= d_state_nxt;
      h_state   <= h_state_nxt;
      data_pend <= data_pend_nxt;
      ack_pend  <= ack_pend_nxt;
      lost_pend <= lost_pend_nxt;
      timer     <= timer_nxt;
      d_blank   <= d_blank_nxt;
      h_blank   <= h_blank_nxt;
      seq_q     <= seq_nxt;
      link_q    <= link_nxt;
      lost_q    <= lost_nxt;
      retry_q   <= retry_nxt;
    end
  end

  always_comb begin
    d_state_nxt   = d_state;
    h_state_nxt   = h_state;
    timer_nxt     = timer;
    seq_nxt       = seq_q;
    link_nxt      = link_q;
    lost_nxt      = lost_q;
    retry_nxt     = retry_q;
    // blanking counters saturate at 2; send_done is only trusted from then on
    d_blank_nxt   = (d_blank == 2'd2) ? d_blank : d_blank + 2'd1;
    h_blank_nxt   = (h_blank == 2'd2) ? h_blank : h_blank + 2'd1;
    data_pend_nxt = data_pend | (update_data && (d_state != D_IDLE));
    ack_pend_nxt  = ack_pend | send_ready_ACK;
    lost_pend_nxt = lost_pend | send_game_lost;
    ack_valid     = ack_received && (received_seqNum_h != seq_q);
    timeout       = (timer == TW'(TIMEOUT_CYCLES - 1));

    case (d_state)
      D_IDLE: begin
        if (update_data || data_pend) begin
          d_state_nxt   = D_LOAD;
          data_pend_nxt = 1'b0;
        end
      end
      D_LOAD: begin
        d_state_nxt = D_SEND;
        d_blank_nxt = 2'd0;
      end
      D_SEND: begin
        if (d_blank == 2'd2 && send_done) begin
          d_state_nxt = D_WAIT_ACK;
          timer_nxt   = '0;
        end
      end
      D_WAIT_ACK: begin
        timer_nxt = timer + TW'(1);
        if (ack_valid) begin
          seq_nxt   = ~seq_q;
          retry_nxt = '0;
          if (data_pend) begin
            d_state_nxt   = D_LOAD;
            data_pend_nxt = update_data;
          end else begin
            d_state_nxt = D_IDLE;
          end
        end else if (timeout) begin
          if (retry_q < RW'(MAX_RETRIES)) begin
            retry_nxt   = retry_q + RW'(1);
            d_state_nxt = D_SEND;
            d_blank_nxt = 2'd0;
          end else begin
            link_nxt    = 1'b1;
            retry_nxt   = '0;
            d_state_nxt = D_IDLE;
          end
        end
      end
      default: d_state_nxt = D_IDLE;
    endcase

    // a request landing on the cycle its flag clears survives via the OR term
    case (h_state)
      H_IDLE: begin
        if (lost_pend) begin
          h_state_nxt   = H_LOAD;
          lost_nxt      = 1'b1;
          lost_pend_nxt = send_game_lost;
        end else if (ack_pend) begin
          h_state_nxt  = H_LOAD;
          lost_nxt     = 1'b0;
          ack_pend_nxt = send_ready_ACK;
        end
      end
      H_LOAD: begin
        h_state_nxt = H_SEND;
        h_blank_nxt = 2'd0;
      end
      H_SEND: begin
        if (h_blank == 2'd2 && send_done_h) h_state_nxt = H_IDLE;
      end
      default: h_state_nxt = H_IDLE;
    endcase

    if (!game_active) begin
      d_state_nxt   = D_IDLE;
      h_state_nxt   = H_IDLE;
      data_pend_nxt = 1'b0;
      ack_pend_nxt  = 1'b0;
      lost_pend_nxt = 1'b0;
      timer_nxt     = '0;
      retry_nxt     = '0;
      link_nxt      = 1'b0;
      seq_nxt       = seq_q;
      lost_nxt      = lost_q;
    end
  end

  assign load_data    = (d_state == D_LOAD) && game_active;
  assign send_start   = (d_state == D_SEND) && (d_blank == 2'd0) && game_active;
  assign load_hnd     = (h_state == H_LOAD) && game_active;
  assign send_start_h = (h_state == H_SEND) && (h_blank == 2'd0) && game_active;
  assign hnd_is_lost  = lost_q;
  assign seq_num      = seq_q;
  assign retry_cnt    = retry_q;
  assign link_down    = link_q;

endmodule

// File: tb/tb_net_tx_scheduler.sv
// Directed bench for net_tx_scheduler: send/ACK, retransmit timing, link_down, coalescing,
// handshake arbitration, game_active abort and async reset.
module tb_net_tx_scheduler;
  logic clk = 1'b0;
  logic rst_l, game_active, update_data, ack_received, received_seqNum_h;
  logic send_ready_ACK, send_game_lost, send_done, send_done_h;
  logic load_data, send_start, load_hnd, hnd_is_lost, send_start_h, seq_num, link_down;
  logic [2:0] retry_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  net_tx_scheduler dut (
    .clk(clk), .rst_l(rst_l), .game_active(game_active), .update_data(update_data),
    .ack_received(ack_received), .received_seqNum_h(received_seqNum_h),
    .send_ready_ACK(send_ready_ACK), .send_game_lost(send_game_lost),
    .send_done(send_done), .send_done_h(send_done_h), .load_data(load_data),
    .send_start(send_start), .load_hnd(load_hnd), .hnd_is_lost(hnd_is_lost),
    .send_start_h(send_start_h), .seq_num(seq_num), .retry_cnt(retry_cnt),
    .link_down(link_down)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    send_done = 1'b1;
    step();
    send_done = 1'b0;
  endtask

  task automatic pulse_ack(input logic seq_h);
    ack_received = 1'b1;
    received_seqNum_h = seq_h;
    step();
    ack_received = 1'b0;
  endtask

  task automatic pulse_update();
    update_data = 1'b1;
    step();
    update_data = 1'b0;
  endtask

  // counts cycles from entry into WAIT_ACK until send_start; optional stale ACK at cycle stale_at
  task automatic wait_start(input int stale_at, input logic stale_seq, output int n, output int loads);
    n = 0;
    loads = 0;
    while (send_start !== 1'b1 && n < 400) begin
      if (n == stale_at) begin
        ack_received = 1'b1;
        received_seqNum_h = stale_seq;
      end
      step();
      ack_received = 1'b0;
      n++;
      if (load_data) loads++;
    end
  endtask

  initial begin
    int n, loads, cnt, cnt2;
    rst_l = 1'b0; game_active = 1'b0; update_data = 1'b0; ack_received = 1'b0;
    received_seqNum_h = 1'b0; send_ready_ACK = 1'b0; send_game_lost = 1'b0;
    send_done = 1'b0; send_done_h = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_l = 1'b1;
    check("rst_load_data", load_data, 0);
    check("rst_send_start", send_start, 0);
    check("rst_load_hnd", load_hnd, 0);
    check("rst_hnd_is_lost", hnd_is_lost, 0);
    check("rst_send_start_h", send_start_h, 0);
    check("rst_seq_num", seq_num, 0);
    check("rst_retry_cnt", retry_cnt, 0);
    check("rst_link_down", link_down, 0);

    // basic send with valid ACK
    game_active = 1'b1;
    step();
    pulse_update();
    check("t1_load_data", load_data, 1);
    check("t1_no_start_yet", send_start, 0);
    step();
    check("t1_send_start", send_start, 1);
    check("t1_load_gone", load_data, 0);
    repeat (9) step();
    pulse_done();
    check("t1_seq_before_ack", seq_num, 0);
    pulse_ack(1'b1);
    check("t1_seq_toggled", seq_num, 1);
    check("t1_retry_zero", retry_cnt, 0);
    step();
    check("t1_idle_no_load", load_data, 0);

    // retransmits; send_done held through blanking cycles must be ignored
    pulse_update();
    step();
    check("t2_send_start", send_start, 1);
    send_done = 1'b1;
    step();
    step();
    send_done = 1'b0;
    step();
    step();
    pulse_done();
    for (int i = 1; i <= 4; i++) begin
      wait_start((i == 2) ? 50 : -1, 1'b1, n, loads);
      check("t2_retx_interval", n, 150);
      check("t2_retry_cnt", retry_cnt, i);
      check("t2_no_reload", loads, 0);
      check("t2_seq_kept", seq_num, 1);
      step();
      step();
      pulse_done();
    end
    n = 0; cnt = 0;
    while (link_down !== 1'b1 && n < 400) begin
      step();
      n++;
      if (send_start) cnt++;
    end
    check("t2_linkdown_delay", n, 150);
    check("t2_linkdown_no_start", cnt, 0);
    check("t2_linkdown_retry", retry_cnt, 0);

    // link_down is sticky but the data path keeps working
    pulse_update();
    check("t2b_load_after_down", load_data, 1);
    check("t2b_link_sticky", link_down, 1);
    step();
    check("t2b_send_start", send_start, 1);
    for (int i = 1; i <= 2; i++) begin
      step();
      step();
      pulse_done();
      wait_start(-1, 1'b0, n, loads);
      check("t2b_retx_interval", n, 150);
      check("t2b_retry_cnt", retry_cnt, i);
    end
    step();
    step();
    pulse_done();
    repeat (10) step();
    game_active = 1'b0;
    step();
    check("t6_retry_cleared", retry_cnt, 0);
    check("t6_link_cleared", link_down, 0);
    check("t6_seq_kept", seq_num, 1);
    game_active = 1'b1;
    cnt = 0; cnt2 = 0;
    repeat (300) begin
      step();
      if (send_start) cnt++;
      if (load_data) cnt2++;
    end
    check("t6_idle_no_start", cnt, 0);
    check("t6_idle_no_load", cnt2, 0);

    // three updates during D_SEND coalesce into one extra load
    pulse_update();
    step();
    check("t3_send_start", send_start, 1);
    repeat (3) pulse_update();
    pulse_done();
    pulse_ack(1'b0);
    check("t3_seq_toggled", seq_num, 0);
    check("t3_extra_load", load_data, 1);
    step();
    check("t3_extra_start", send_start, 1);
    step();
    step();
    pulse_done();
    pulse_ack(1'b1);
    check("t3_seq_again", seq_num, 1);
    cnt = 0;
    repeat (20) begin
      step();
      if (load_data) cnt++;
    end
    check("t3_no_more_loads", cnt, 0);

    // handshake arbitration: lost beats ACK
    send_ready_ACK = 1'b1;
    send_game_lost = 1'b1;
    step();
    send_ready_ACK = 1'b0;
    send_game_lost = 1'b0;
    check("t4_no_load_yet", load_hnd, 0);
    step();
    check("t4_load_lost", load_hnd, 1);
    check("t4_type_lost", hnd_is_lost, 1);
    step();
    check("t4_start_h_lost", send_start_h, 1);
    check("t4_load_gone", load_hnd, 0);
    check("t4_type_holds", hnd_is_lost, 1);
    step();
    step();
    send_done_h = 1'b1;
    step();
    send_done_h = 1'b0;
    step();
    check("t4_load_ack", load_hnd, 1);
    check("t4_type_ack", hnd_is_lost, 0);
    step();
    check("t4_start_h_ack", send_start_h, 1);
    step();
    step();
    send_done_h = 1'b1;
    step();
    send_done_h = 1'b0;
    cnt = 0;
    repeat (10) begin
      step();
      if (load_hnd) cnt++;
    end
    check("t4_no_more_hnd", cnt, 0);

    // async reset mid-send
    pulse_update();
    step();
    check("t5_send_start", send_start, 1);
    rst_l = 1'b0;
    #1;
    check("t5_rst_start", send_start, 0);
    check("t5_rst_seq", seq_num, 0);
    check("t5_rst_load", load_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
